// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin / fixed-priority bus arbiter.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational winner selection: rotating scan from ptr, or lowest index in fixed mode.
module bus_arbiter_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned  CHANNELS = 2,
  localparam int unsigned GW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [GW-1:0]       ptr,
  input  logic                mode,
  output logic                valid_c,
  output logic [GW-1:0]       idx_c
);

  localparam int unsigned RW = idx_width(2 * CHANNELS);

  // Doubled request vector lets the rotating scan run without a modulo.
  logic [2*CHANNELS-1:0] req2;
  logic [RW-1:0]         pos;

  assign req2 = {req, req};

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    pos     = '0;
    if (mode) begin
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (req[i]) begin
          valid_c = 1'b1;
          idx_c   = GW'(i);
        end
      end
    end else begin
      // Scan farthest offset first so the nearest requester to ptr is the last write.
      for (int off = int'(CHANNELS) - 1; off >= 0; off--) begin
        pos = RW'(ptr) + RW'(off);
        if (req2[pos]) begin
          valid_c = 1'b1;
          idx_c   = (pos >= RW'(CHANNELS)) ? GW'(pos - RW'(CHANNELS)) : GW'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel request/ready arbiter onto one downstream bus, with registered read
// data return and optional per-transaction timeout.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MODE     = ARB_RR,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [CHANNELS-1:0]    i_request,
  input  logic [CHANNELS-1:0]    i_rw,
  input  logic [CHANNELS*AW-1:0] i_address,
  input  logic [CHANNELS*DW-1:0] i_wdata,
  output logic [CHANNELS-1:0]    o_ready,
  output logic [DW-1:0]          o_rdata,
  output logic                   o_bus_request,
  output logic                   o_bus_rw,
  output logic [AW-1:0]          o_bus_address,
  output logic [DW-1:0]          o_bus_wdata,
  input  logic                   i_bus_ready,
  input  logic [DW-1:0]          i_bus_rdata,
  output logic                   o_timeout
);

  localparam int unsigned GW = idx_width(CHANNELS);
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_rw_q, bus_rw_d;
  logic [AW-1:0]        bus_addr_q, bus_addr_d;
  logic [DW-1:0]        bus_wdata_q, bus_wdata_d;
  logic [CHANNELS-1:0]  ready_q, ready_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 timeout_q, timeout_d;

  logic                 pick_valid_c;
  logic [GW-1:0]        pick_idx_c;
  logic                 timeout_hit_c;
  logic [AW-1:0]        addr_a  [CHANNELS];
  logic [DW-1:0]        wdata_a [CHANNELS];

  bus_arbiter_pick #(
    .CHANNELS (CHANNELS)
  ) u_pick (
    .req     (i_request),
    .ptr     (ptr_q),
    .mode    (MODE == ARB_FIXED),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  // Unpack the flat per-channel buses so the grant can index them directly.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      addr_a[c]  = i_address[c*AW +: AW];
      wdata_a[c] = i_wdata[c*DW +: DW];
    end
  end

  assign timeout_hit_c = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ready_d     = '0;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          state_d     = ST_BUSY;
          grant_d     = pick_idx_c;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_rw_d    = i_rw[pick_idx_c];
          bus_addr_d  = addr_a[pick_idx_c];
          bus_wdata_d = wdata_a[pick_idx_c];
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // A real completion wins over a timeout landing in the same cycle.
        if (i_bus_ready || timeout_hit_c) begin
          state_d          = ST_ACK;
          ready_d[grant_q] = 1'b1;
          bus_req_d        = 1'b0;
          bus_rw_d         = 1'b0;
          bus_addr_d       = '0;
          bus_wdata_d      = '0;
          rdata_d          = i_bus_ready ? i_bus_rdata : '0;
          timeout_d        = timeout_q | ~i_bus_ready;
        end
      end
      ST_ACK: begin
        ptr_d   = (grant_q == GW'(CHANNELS - 1)) ? '0 : grant_q + GW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_rdata       = rdata_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench: a 4-channel round-robin arbiter with timeout and a
// 3-channel fixed-priority arbiter, driven by directed request sets.
module tb_bus_arbiter_rr;

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] rdata;
    logic        to;
    int          gap;
  } ack_t;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: 4 channels, round-robin, TIMEOUT=8
  logic [3:0]   a_req, a_rw, a_rdy;
  logic [127:0] a_addr, a_wdata;
  logic [31:0]  a_rdata, a_baddr, a_bwdata, a_brdata;
  logic         a_breq, a_brw, a_bready, a_to;

  bus_arbiter_rr #(.CHANNELS(4), .AW(32), .DW(32), .MODE(0), .TIMEOUT(8)) u_dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_request(a_req), .i_rw(a_rw),
    .i_address(a_addr), .i_wdata(a_wdata), .o_ready(a_rdy), .o_rdata(a_rdata),
    .o_bus_request(a_breq), .o_bus_rw(a_brw), .o_bus_address(a_baddr),
    .o_bus_wdata(a_bwdata), .i_bus_ready(a_bready), .i_bus_rdata(a_brdata),
    .o_timeout(a_to)
  );

  // ---------------- instance F: 3 channels, fixed priority, no timeout
  logic [2:0]  f_req, f_rw, f_rdy;
  logic [95:0] f_addr, f_wdata;
  logic [31:0] f_rdata, f_baddr, f_bwdata, f_brdata;
  logic        f_breq, f_brw, f_bready, f_to;

  bus_arbiter_rr #(.CHANNELS(3), .AW(32), .DW(32), .MODE(1), .TIMEOUT(0)) u_dut_f (
    .i_clock(clk), .i_reset(rst_n), .i_request(f_req), .i_rw(f_rw),
    .i_address(f_addr), .i_wdata(f_wdata), .o_ready(f_rdy), .o_rdata(f_rdata),
    .o_bus_request(f_breq), .o_bus_rw(f_brw), .o_bus_address(f_baddr),
    .o_bus_wdata(f_bwdata), .i_bus_ready(f_bready), .i_bus_rdata(f_brdata),
    .o_timeout(f_to)
  );

  int          a_left [4];
  int          f_left [3];
  logic        a_f_rw    [4];
  logic [31:0] a_f_addr  [4];
  logic [31:0] a_f_wdata [4];
  int          a_resp_lat = 3;
  logic        a_resp_en = 1'b1;
  logic        a_force_rdy = 1'b0;
  logic [31:0] a_resp_data = 32'h0;
  logic [31:0] f_resp_data = 32'h3333_0000;

  ack_t a_exp_ack[$];
  bus_t a_exp_bus[$];
  ack_t f_exp_ack[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_a(input int c, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    a_f_rw[c] = rw; a_f_addr[c] = addr; a_f_wdata[c] = wd;
    a_rw[c] = rw; a_addr[c*32 +: 32] = addr; a_wdata[c*32 +: 32] = wd;
  endtask

  // Expected bus transfer (from the bench's own channel fields) plus the completion.
  task automatic push_a(input int c, input int len, input logic [31:0] rd, input logic to, input int gap);
    bus_t b;
    ack_t e;
    b.rw = a_f_rw[c]; b.addr = a_f_addr[c]; b.wdata = a_f_wdata[c]; b.len = len;
    e.rdy = 4'b0001 << c; e.rdata = rd; e.to = to; e.gap = gap;
    a_exp_bus.push_back(b);
    a_exp_ack.push_back(e);
  endtask

  task automatic push_f(input logic [3:0] rdy);
    ack_t e;
    e.rdy = rdy; e.rdata = f_resp_data; e.to = 1'b0; e.gap = 0;
    f_exp_ack.push_back(e);
  endtask

  function automatic bit any_left();
    bit r = 1'b0;
    for (int c = 0; c < 4; c++) if (a_left[c] > 0) r = 1'b1;
    for (int c = 0; c < 3; c++) if (f_left[c] > 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while ((a_exp_ack.size() != 0 || a_exp_bus.size() != 0 || f_exp_ack.size() != 0 || any_left())
           && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: pending a_ack=%0d a_bus=%0d f_ack=%0d after %0d cycles, required 0",
               name, a_exp_ack.size(), a_exp_bus.size(), f_exp_ack.size(), n);
      a_exp_ack.delete(); a_exp_bus.delete(); f_exp_ack.delete();
      for (int c = 0; c < 4; c++) a_left[c] = 0;
      for (int c = 0; c < 3; c++) f_left[c] = 0;
    end
    repeat (3) @(posedge clk);
  endtask

  // Masters: hold request until own o_ready, then re-request while work remains.
  initial begin
    a_req = '0; f_req = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        if (a_rdy[c] && a_left[c] > 0) a_left[c]--;
        a_req[c] = (a_left[c] > 0);
      end
      for (int c = 0; c < 3; c++) begin
        if (f_rdy[c] && f_left[c] > 0) f_left[c]--;
        f_req[c] = (f_left[c] > 0);
      end
    end
  end

  // Downstream slaves: A answers after a_resp_lat request cycles, F after 2.
  initial begin
    int a_cnt = 0;
    int f_cnt = 0;
    a_bready = 1'b0; a_brdata = '0; f_bready = 1'b0; f_brdata = '0;
    forever begin
      @(posedge clk); #1;
      if (a_breq) begin
        a_cnt++;
        a_bready = a_resp_en && (a_cnt == a_resp_lat);
        a_brdata = a_bready ? a_resp_data : 32'h0;
      end else begin
        a_cnt    = 0;
        a_bready = a_force_rdy;
        a_brdata = 32'hBAD0_BAD0;
      end
      if (f_breq) begin
        f_cnt++;
        f_bready = (f_cnt == 2);
        f_brdata = f_bready ? f_resp_data : 32'h0;
      end else begin
        f_cnt    = 0;
        f_bready = 1'b0;
        f_brdata = 32'h0;
      end
    end
  end

  // Completion monitors.
  initial begin
    ack_t e;
    int   a_last = 0;
    forever begin
      @(negedge clk);
      if (a_rdy != 4'b0) begin
        if (a_exp_ack.size() == 0) check("a_ack_unexpected", 32'(a_rdy), 32'h0);
        else begin
          e = a_exp_ack.pop_front();
          check("a_ready", 32'(a_rdy), 32'(e.rdy));
          check("a_rdata", a_rdata, e.rdata);
          check("a_timeout", 32'(a_to), 32'(e.to));
          if (e.gap != 0) check("a_ack_gap", 32'(cyc - a_last), 32'(e.gap));
        end
        a_last = cyc;
      end
      if (f_rdy != 3'b0) begin
        if (f_exp_ack.size() == 0) check("f_ack_unexpected", 32'(f_rdy), 32'h0);
        else begin
          e = f_exp_ack.pop_front();
          check("f_ready", 32'(f_rdy), 32'(e.rdy));
          check("f_rdata", f_rdata, e.rdata);
        end
      end
    end
  end

  // Downstream monitor for A: fields at request rise, length and idle zeros at fall.
  initial begin
    bus_t b;
    logic prev = 1'b0;
    int   len = 0;
    int   cur_len = 0;
    forever begin
      @(negedge clk);
      if (a_breq && !prev) begin
        len = 0;
        cur_len = 0;
        if (a_exp_bus.size() == 0) check("a_bus_unexpected", 32'(a_breq), 32'h0);
        else begin
          b = a_exp_bus.pop_front();
          cur_len = b.len;
          check("a_bus_rw", 32'(a_brw), 32'(b.rw));
          check("a_bus_addr", a_baddr, b.addr);
          check("a_bus_wdata", a_bwdata, b.wdata);
        end
      end
      if (a_breq) len++;
      if (!a_breq && prev) begin
        if (cur_len != 0) check("a_bus_len", 32'(len), 32'(cur_len));
        check("a_bus_addr_idle", a_baddr, 32'h0);
      end
      prev = a_breq;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_rw = '0; a_addr = '0; a_wdata = '0;
    f_rw = '1; f_addr = '0; f_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      a_left[c] = 0;
      set_a(c, c[0], 32'h1000_0000 + 32'(c * 256), 32'hA000_0000 + 32'(c));
    end
    for (int c = 0; c < 3; c++) begin
      f_left[c] = 0;
      f_addr[c*32 +: 32] = 32'h2000_0000 + 32'(c);
      f_wdata[c*32 +: 32] = 32'(c);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_breq", 32'(a_breq), 32'h0);
    check("rst_a_ready", 32'(a_rdy), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_a_timeout", 32'(a_to), 32'h0);
    check("rst_a_addr", a_baddr, 32'h0);
    check("rst_f_ready", 32'(f_rdy), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ch0 and ch1 together from pointer 0: ch0 first, ch1 one bubble later.
    a_resp_data = 32'h1111_2222;
    push_a(0, 3, 32'h1111_2222, 1'b0, 0);
    push_a(1, 3, 32'h1111_2222, 1'b0, 5);
    a_left[0] = 1; a_left[1] = 1;
    wait_drain("rr_pair");

    // All four continuously: pointer now 2, so 2,3,0,1,2,3,0,1.
    a_resp_data = 32'h2222_3333;
    push_a(2, 3, 32'h2222_3333, 1'b0, 0);
    push_a(3, 3, 32'h2222_3333, 1'b0, 5);
    push_a(0, 3, 32'h2222_3333, 1'b0, 5);
    push_a(1, 3, 32'h2222_3333, 1'b0, 5);
    push_a(2, 3, 32'h2222_3333, 1'b0, 5);
    push_a(3, 3, 32'h2222_3333, 1'b0, 5);
    push_a(0, 3, 32'h2222_3333, 1'b0, 5);
    push_a(1, 3, 32'h2222_3333, 1'b0, 5);
    for (int c = 0; c < 4; c++) a_left[c] = 2;
    wait_drain("rr_all");

    // Slave never answers: 8 request cycles, then abort with zero data.
    a_resp_en = 1'b0;
    push_a(3, 8, 32'h0, 1'b1, 0);
    a_left[3] = 1;
    wait_drain("timeout");
    a_resp_en = 1'b1;

    // Read returning data; timeout flag stays set.
    set_a(0, 1'b0, 32'h1000_0400, 32'h5555_AAAA);
    a_resp_data = 32'hCAFE_F00D;
    push_a(0, 3, 32'hCAFE_F00D, 1'b1, 0);
    a_left[0] = 1;
    wait_drain("read");
    check("rdata_hold", a_rdata, 32'hCAFE_F00D);

    // Stray downstream ready while idle must not complete anything.
    a_force_rdy = 1'b1;
    repeat (4) @(posedge clk);
    a_force_rdy = 1'b0;
    #1;
    check("stray_ready_rdata", a_rdata, 32'hCAFE_F00D);
    check("stray_ready_breq", 32'(a_breq), 32'h0);

    // Fixed priority: ch0 starves ch2; then ch1 alone; then ch1 beats ch2.
    push_f(4'b0001); push_f(4'b0001); push_f(4'b0001); push_f(4'b0100);
    f_left[0] = 3; f_left[2] = 1;
    wait_drain("fixed_starve");
    push_f(4'b0010);
    f_left[1] = 1;
    wait_drain("fixed_ch1");
    push_f(4'b0010); push_f(4'b0100);
    f_left[1] = 1; f_left[2] = 1;
    wait_drain("fixed_pair");

    // Reset in the middle of a busy transaction (pointer is 1 beforehand).
    a_resp_en = 1'b0;
    push_a(2, 0, 32'h0, 1'b0, 0);
    a_exp_ack.delete();
    a_left[2] = 1;
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!a_breq && n < 20);
      check("mid_busy_reached", 32'(a_breq), 32'h1);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) a_left[c] = 0;
    #1;
    check("async_rst_breq", 32'(a_breq), 32'h0);
    check("async_rst_ready", 32'(a_rdy), 32'h0);
    check("async_rst_timeout", 32'(a_to), 32'h0);
    check("async_rst_rdata", a_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    a_resp_en = 1'b1;
    repeat (2) @(posedge clk);

    // After reset the pointer is 0 again: 0,1,3 rather than 1,3,0.
    a_resp_data = 32'h6666_0000;
    push_a(0, 3, 32'h6666_0000, 1'b0, 0);
    push_a(1, 3, 32'h6666_0000, 1'b0, 5);
    push_a(3, 3, 32'h6666_0000, 1'b0, 5);
    a_left[0] = 1; a_left[1] = 1; a_left[3] = 1;
    wait_drain("post_reset");

    check("a_ack_queue_empty", 32'(a_exp_ack.size()), 32'h0);
    check("a_bus_queue_empty", 32'(a_exp_bus.size()), 32'h0);
    check("f_ack_queue_empty", 32'(f_exp_ack.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
